// File: rtl/mipi_img_crop.sv
// Crops a rectangular window out of the CSI-2 parallel pixel stream and measures
// incoming frame geometry (columns, rows, frame count, line-length consistency).
module mipi_img_crop #(
   parameter int unsigned DATA_WIDTH = 10
) (
   input  logic                  img_clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [15:0]           crop_x0,
   input  logic [15:0]           crop_y0,
   input  logic [15:0]           crop_w,
   input  logic [15:0]           crop_h,
   input  logic [DATA_WIDTH-1:0] dati,
   input  logic                  dvi,
   input  logic                  lvi,
   input  logic                  fvi,
   output logic [DATA_WIDTH-1:0] dato,
   output logic                  dvo,
   output logic                  lvo,
   output logic                  fvo,
   output logic [15:0]           num_cols,
   output logic [15:0]           num_rows,
   output logic [15:0]           frame_count,
   output logic                  line_len_err
);

   localparam logic [0:0] S_WAIT   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   logic [0:0]  state;
   logic        lvi_d, fvi_d;
   logic [15:0] x0, y0, w, h;
   logic [15:0] col, row;
   logic [15:0] line_len, ref_len;

   logic        fs, fe, le;
   logic        in_active, emit;
   logic [15:0] x0_e, y0_e, w_e, h_e, row_e;
   logic [16:0] x_end, y_end;
   logic        col_in, row_in, pix_ok;

   // On the FS cycle the shadows are not loaded yet, so the window uses crop_* directly
   always_comb begin
      fs        = fvi & ~fvi_d;
      fe        = ~fvi & fvi_d;
      le        = ~lvi & lvi_d;
      in_active = (state == S_ACTIVE) & enable;
      emit      = enable & ((state == S_ACTIVE) | fs);
      x0_e      = fs ? crop_x0 : x0;
      y0_e      = fs ? crop_y0 : y0;
      w_e       = fs ? crop_w  : w;
      h_e       = fs ? crop_h  : h;
      row_e     = fs ? '0      : row;
      x_end     = {1'b0, x0_e} + {1'b0, w_e};
      y_end     = {1'b0, y0_e} + {1'b0, h_e};
      col_in    = (w_e == '0) | ((col >= x0_e) & ({1'b0, col} < x_end));
      row_in    = (h_e == '0) | ((row_e >= y0_e) & ({1'b0, row_e} < y_end));
      pix_ok    = lvi & dvi & row_in & col_in;
   end

   // fvi_d resets high so that releasing reset inside a frame is not seen as FS
   always_ff @(posedge img_clk or posedge reset) begin
      if (reset) begin
         lvi_d <= 1'b0;
         fvi_d <= 1'b1;
         state <= S_WAIT;
      end else begin
         lvi_d <= lvi;
         fvi_d <= fvi;
         if (!enable)
            state <= S_WAIT;
         else if (state == S_WAIT && fs)
            state <= S_ACTIVE;
         else if (state == S_ACTIVE && fe)
            state <= S_WAIT;
      end
   end

   always_ff @(posedge img_clk or posedge reset) begin
      if (reset) begin
         x0  <= '0;
         y0  <= '0;
         w   <= '0;
         h   <= '0;
         col <= '0;
         row <= '0;
      end else begin
         if (fs) begin
            x0 <= crop_x0;
            y0 <= crop_y0;
            w  <= crop_w;
            h  <= crop_h;
         end
         if (!lvi)
            col <= '0;
         else if (dvi && col != '1)
            col <= col + 16'd1;
         if (fs)
            row <= '0;
         else if (le && in_active && row != '1)
            row <= row + 16'd1;
      end
   end

   always_ff @(posedge img_clk or posedge reset) begin
      if (reset) begin
         dato <= '0;
         dvo  <= 1'b0;
         lvo  <= 1'b0;
         fvo  <= 1'b0;
      end else if (emit) begin
         fvo <= fvi;
         lvo <= lvi & row_in;
         dvo <= pix_ok;
         if (pix_ok)
            dato <= dati;
      end else begin
         fvo <= 1'b0;
         lvo <= 1'b0;
         dvo <= 1'b0;
      end
   end

   always_ff @(posedge img_clk or posedge reset) begin
      if (reset) begin
         line_len     <= '0;
         ref_len      <= '0;
         line_len_err <= 1'b0;
         num_cols     <= '0;
         num_rows     <= '0;
         frame_count  <= '0;
      end else begin
         if (fs)
            line_len_err <= 1'b0;
         else if (le && in_active) begin
            line_len <= col;
            if (row == '0)
               ref_len <= col;
            else if (col != ref_len)
               line_len_err <= 1'b1;
         end
         if (fe && in_active) begin
            num_rows    <= row + {15'd0, le};
            num_cols    <= le ? col : line_len;
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule
